if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch unit and the decode stage of the MIPS pipeline CPU.
- Latches the fetched instruction, PC and PC+8 each cycle.
- Detects instruction-fetch address exceptions (AdEL) and tags each decoded instruction with a branch-delay-slot flag (BD), for CP0/EPC handling downstream.
- Supports a stall (hold) and a flush (bubble insert) for hazards, interrupts and eret.

Parameters:
- PC_RESET, 32'h00003000, PC value loaded into PC_D on reset.
- IM_LO, 32'h00003000, lowest legal fetch address (inclusive).
- IM_HI, 32'h00006FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, ExcCode reported for an illegal fetch address.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- Instr_F  input  32  instruction word from the fetch unit.
- PC_F  input  32  PC of Instr_F.
- PC8_F  input  32  PC_F+8 from the fetch unit (link address).
- stall  input  1  hazard stall; hold all state.
- flush  input  1  insert a bubble (interrupt/exception entry or eret).
- Instr_D  output  32  instruction to decode; 0 (nop) when bubble or excepted.
- PC_D  output  32  PC of Instr_D.
- PC8_D  output  32  link address of Instr_D.
- ExcCode_D  output  5  0 = none; EXC_ADEL on a fetch address fault.
- BD_D  output  1  Instr_D sits in the delay slot of a branch or jump.
- valid_D  output  1  Instr_D is a real fetched instruction (not a bubble).

Behaviour:
- Update priority on each posedge: reset > flush > stall > load.
- Reset:
  - Instr_D=0, PC_D=PC_RESET, PC8_D=PC_RESET+8, ExcCode_D=0, BD_D=0, valid_D=0.
  - Internal prev_br=0.
- Flush:
  - Instr_D=0, ExcCode_D=0, BD_D=0, valid_D=0, prev_br=0.
  - PC_D=PC_F and PC8_D=PC8_F, so a bubble still carries a meaningful PC.
  - Flush overrides a simultaneous stall.
- Stall (no flush): every output register and prev_br holds its value.
- Load:
  - fault = (PC_F[1:0]!=0) | (PC_F<IM_LO) | (PC_F>IM_HI), unsigned compares.
  - PC_D=PC_F, PC8_D=PC8_F, valid_D=1.
  - Instr_D = fault ? 0 : Instr_F.
  - ExcCode_D = fault ? EXC_ADEL : 0.
  - BD_D = prev_br.
  - prev_br = is_br(Instr_F) & ~fault.
- is_br (combinational), true for:
  - opcode 000100 beq, 000101 bne, 000110 blez, 000111 bgtz;
  - opcode 000001 regimm (bltz/bgez);
  - opcode 000010 j, 000011 jal;
  - opcode 000000 with funct 001000 jr or 001001 jalr.
- prev_br semantics:
  - Refers only to the last loaded instruction.
  - Stall cycles do not change it, so BD survives any number of stall cycles.
  - Flush clears it: the instruction after a flush is never marked BD.
- Latency: exactly one cycle from the F-side inputs to the D-side outputs when not stalled.
- Back-to-back branches: the second branch gets BD_D=1, and its own successor also gets BD_D=1.
- Reset asserted mid-stall or mid-flush: reset wins and all state is cleared.
- Faulting fetch: the faulting slot's own BD_D still reflects prev_br (needed for EPC=PC-4 handling). The next instruction gets BD_D=0.

Decomposition:
- Add to define.v:
  - opcode and funct constants (BEQ, BNE, BLEZ, BGTZ, REGIMM, J, JAL, SPECIAL, JR, JALR);
  - `EXC_ADEL;
  - IM address bounds.
- One combinational sub-module, br_class: input instr[31:0], output is_br. The decode stage reuses it.

Test Plan:
- Reset, then hold reset for 2 cycles:
  - PC_D=0x3000, PC8_D=0x3008, Instr_D=0, valid_D=0, BD_D=0, ExcCode_D=0.
- Load beq (0x10000003 at 0x3000), then addu at 0x3004:
  - Cycle 1: Instr_D=0x10000003, BD_D=0.
  - Cycle 2: Instr_D=addu, BD_D=1, PC_D=0x3004.
- jal at 0x3008, stall for 3 cycles, then the slot instruction at 0x300C:
  - Outputs hold during the stall.
  - Slot instruction loads with BD_D=1.
- PC_F=0x3002, Instr_F=0x12345678:
  - Instr_D=0, ExcCode_D=4, valid_D=1.
  - Next instruction gets BD_D=0 even though 0x12345678 decodes as a branch (opcode 000100).
- PC_F=0x2FFC and PC_F=0x7000: both give ExcCode_D=4.
- jr loaded, then flush and stall together with PC_F=0x4180:
  - Instr_D=0, valid_D=0, PC_D=0x4180, BD_D=0.
  - The following load gets BD_D=0.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID pipeline register and the branch classifier:
// opcode/funct values, fetch address window, and the AdEL exception code.
package if_id_reg_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF    = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE     = 5'd0;
    localparam logic [4:0]  EXC_ADEL_DEF = 5'd4;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // A fetch faults when misaligned or outside the instruction memory window.
    function automatic logic fetch_fault(input logic [31:0] pc,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
        return (pc[1:0] != 2'b00) | (pc < lo) | (pc > hi);
    endfunction

endpackage

// File: rtl/if_id_reg_br_class.sv
// Combinational branch/jump classifier; the decode stage reuses it.
module br_class
    import if_id_reg_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_br
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic       unused_bits_s;

    assign opcode_s      = instr[31:26];
    assign funct_s       = instr[5:0];
    assign unused_bits_s = ^instr[25:6];

    // Classify by opcode; SPECIAL needs the funct field to spot jr/jalr.
    always_comb begin
        is_br = 1'b0;
        case (opcode_s)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM, OP_J, OP_JAL: is_br = 1'b1;
            OP_SPECIAL: begin
                if ((funct_s == FN_JR) || (funct_s == FN_JALR)) begin
                    is_br = 1'b1;
                end else begin
                    is_br = 1'b0;
                end
            end
            default: is_br = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches instruction/PC/PC+8, flags fetch address
// faults (AdEL) and marks branch-delay-slot instructions, with stall and flush.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_LO    = IM_LO_DEF,
    parameter logic [31:0] IM_HI    = IM_HI_DEF,
    parameter logic [4:0]  EXC_ADEL = EXC_ADEL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC_F,
    input  logic [31:0] PC8_F,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic [4:0]  ExcCode_D,
    output logic        BD_D,
    output logic        valid_D
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc8_q, pc8_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic        valid_q, valid_d;
    logic        prev_br_q, prev_br_d;
    logic        is_br_s;
    logic        fault_s;

    br_class u_br_class (
        .instr (Instr_F),
        .is_br (is_br_s)
    );

    assign fault_s = fetch_fault(PC_F, IM_LO, IM_HI);

    // Next-state selection: flush beats stall beats a normal load.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc8_d     = pc8_q;
        exc_d     = exc_q;
        bd_d      = bd_q;
        valid_d   = valid_q;
        prev_br_d = prev_br_q;
        if (flush) begin
            instr_d   = 32'h0000_0000;
            pc_d      = PC_F;
            pc8_d     = PC8_F;
            exc_d     = EXC_NONE;
            bd_d      = 1'b0;
            valid_d   = 1'b0;
            prev_br_d = 1'b0;
        end else if (stall) begin
            prev_br_d = prev_br_q;
        end else begin
            instr_d   = fault_s ? 32'h0000_0000 : Instr_F;
            pc_d      = PC_F;
            pc8_d     = PC8_F;
            exc_d     = fault_s ? EXC_ADEL : EXC_NONE;
            bd_d      = prev_br_q;
            valid_d   = 1'b1;
            prev_br_d = is_br_s & ~fault_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= 32'h0000_0000;
            pc_q      <= PC_RESET;
            pc8_q     <= PC_RESET + 32'd8;
            exc_q     <= EXC_NONE;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
            prev_br_q <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc8_q     <= pc8_d;
            exc_q     <= exc_d;
            bd_q      <= bd_d;
            valid_q   <= valid_d;
            prev_br_q <= prev_br_d;
        end
    end

    assign Instr_D   = instr_q;
    assign PC_D      = pc_q;
    assign PC8_D     = pc8_q;
    assign ExcCode_D = exc_q;
    assign BD_D      = bd_q;
    assign valid_D   = valid_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed scenarios then random traffic, all checked
// against a behavioural model of the pipeline-register rules.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] Instr_F, PC_F, PC8_F;
    logic [31:0] Instr_D, PC_D, PC8_D;
    logic [4:0]  ExcCode_D;
    logic        BD_D, valid_D;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] m_instr, m_pc, m_pc8;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid, m_prev;

    if_id_reg dut (
        .clk       (clk),
        .reset     (reset),
        .Instr_F   (Instr_F),
        .PC_F      (PC_F),
        .PC8_F     (PC8_F),
        .stall     (stall),
        .flush     (flush),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .PC8_D     (PC8_D),
        .ExcCode_D (ExcCode_D),
        .BD_D      (BD_D),
        .valid_D   (valid_D)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_br(input logic [31:0] ins);
        int op, fn;
        op = int'(ins >> 26);
        fn = int'(ins & 32'd63);
        return (op inside {1, 2, 3, 4, 5, 6, 7}) || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    function automatic bit m_fault(input logic [31:0] pc);
        return ((pc % 32'd4) != 32'd0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        bit f;
        if (reset) begin
            m_instr = 32'd0; m_pc = 32'h3000; m_pc8 = 32'h3008;
            m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0; m_prev = 1'b0;
        end else if (flush) begin
            m_instr = 32'd0; m_pc = PC_F; m_pc8 = PC8_F;
            m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0; m_prev = 1'b0;
        end else if (!stall) begin
            f = m_fault(PC_F);
            m_instr = f ? 32'd0 : Instr_F;
            m_pc = PC_F; m_pc8 = PC8_F;
            m_exc = f ? 5'd4 : 5'd0;
            m_bd = m_prev;
            m_valid = 1'b1;
            m_prev = m_is_br(Instr_F) && !f;
        end
    endtask

    task automatic chk_model();
        chk("Instr_D", Instr_D, m_instr);
        chk("PC_D", PC_D, m_pc);
        chk("PC8_D", PC8_D, m_pc8);
        chk("ExcCode_D", {27'd0, ExcCode_D}, {27'd0, m_exc});
        chk("BD_D", {31'd0, BD_D}, {31'd0, m_bd});
        chk("valid_D", {31'd0, valid_D}, {31'd0, m_valid});
    endtask

    task automatic step(input logic rst, input logic fl, input logic st,
                        input logic [31:0] ins, input logic [31:0] pc);
        reset = rst; flush = fl; stall = st;
        Instr_F = ins; PC_F = pc; PC8_F = pc + 32'd8;
        @(posedge clk);
        model_clock();
        #1;
        chk_model();
    endtask

    initial begin
        logic [31:0] r_ins, r_pc, r_lo;
        int          r_op;
        logic        r_rst, r_fl, r_st;

        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        Instr_F = 32'd0; PC_F = 32'd0; PC8_F = 32'd0;

        // Reset held for two cycles
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        chk("rst_PC_D", PC_D, 32'h0000_3000);
        chk("rst_PC8_D", PC8_D, 32'h0000_3008);
        chk("rst_Instr_D", Instr_D, 32'h0000_0000);
        chk("rst_valid", {31'd0, valid_D}, 32'd0);

        // beq then addu in its delay slot
        step(1'b0, 1'b0, 1'b0, 32'h1000_0003, 32'h0000_3000);
        chk("beq_Instr_D", Instr_D, 32'h1000_0003);
        chk("beq_BD", {31'd0, BD_D}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_3004);
        chk("slot_BD", {31'd0, BD_D}, 32'd1);
        chk("slot_PC_D", PC_D, 32'h0000_3004);

        // jal, 3 stall cycles, then its slot
        step(1'b0, 1'b0, 1'b0, 32'h0C00_0C00, 32'h0000_3008);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'hFFFF_0000 + i, 32'h0000_5000);
            chk("stall_hold_Instr", Instr_D, 32'h0C00_0C00);
        end
        step(1'b0, 1'b0, 1'b0, 32'h2401_0001, 32'h0000_300C);
        chk("jal_slot_BD", {31'd0, BD_D}, 32'd1);

        // Misaligned fetch of a branch-looking word
        step(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_3002);
        chk("adel_Instr_D", Instr_D, 32'd0);
        chk("adel_exc", {27'd0, ExcCode_D}, 32'd4);
        chk("adel_valid", {31'd0, valid_D}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_3010);
        chk("after_adel_BD", {31'd0, BD_D}, 32'd0);

        // Range boundaries
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_2FFC);
        chk("lo_bound_exc", {27'd0, ExcCode_D}, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_7000);
        chk("hi_bound_exc", {27'd0, ExcCode_D}, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_6FFC);
        chk("hi_edge_exc", {27'd0, ExcCode_D}, 32'd0);

        // jr, then flush together with stall
        step(1'b0, 1'b0, 1'b0, 32'h03E0_0008, 32'h0000_3014);
        step(1'b0, 1'b1, 1'b1, 32'h0022_1821, 32'h0000_4180);
        chk("flush_Instr_D", Instr_D, 32'd0);
        chk("flush_valid", {31'd0, valid_D}, 32'd0);
        chk("flush_PC_D", PC_D, 32'h0000_4180);
        chk("flush_BD", {31'd0, BD_D}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_4180);
        chk("after_flush_BD", {31'd0, BD_D}, 32'd0);

        // Reset during stall
        step(1'b0, 1'b0, 1'b0, 32'h0800_0000, 32'h0000_4184);
        step(1'b1, 1'b0, 1'b1, 32'h0022_1821, 32'h0000_4188);
        chk("rst_in_stall_PC", PC_D, 32'h0000_3000);
        step(1'b0, 1'b0, 1'b0, 32'h0022_1821, 32'h0000_3000);
        chk("rst_clears_prev", {31'd0, BD_D}, 32'd0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_op  = $urandom_range(0, 9);
            r_lo  = $urandom;
            if (r_op <= 7) begin
                r_ins = {r_op[5:0], r_lo[25:0]};
                if (r_op == 0 && $urandom_range(0, 1) == 1) begin
                    r_ins[5:0] = ($urandom_range(0, 1) == 1) ? 6'b001000 : 6'b001001;
                end
            end else begin
                r_ins = r_lo;
            end
            if ($urandom_range(0, 3) != 0) begin
                r_pc = 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
            end else begin
                r_pc = $urandom;
            end
            step(r_rst, r_fl, r_st, r_ins, r_pc);
            if ($urandom_range(0, 7) == 0) begin
                PC8_F = $urandom;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
